// File: rtl/tensor_pkg.sv
// ============================================================================
//  Module      : tensor_pkg
//  Description : Types and constants shared by tensor_core and its result path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tensor_pkg;

    localparam int TC_NUM_THREADS   = 32;
    localparam int TC_XLEN          = 32;
    localparam int TC_NUM_WARPS     = 8;
    localparam int TC_NUM_REGS      = 32;
    localparam int TC_NUM_TILE_BUFS = 4;
    localparam int TC_NUM_TILE_REGS = 2;
    localparam int TC_WID_W         = $clog2(TC_NUM_WARPS);
    localparam int TC_RD_W          = $clog2(TC_NUM_REGS);
    localparam int TC_ROW_W         = TC_NUM_THREADS * TC_XLEN;

    typedef enum logic [1:0] {
        OP_MMA   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_NOP   = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        LOAD_A    = 2'd0,
        LOAD_B    = 2'd1,
        LOAD_C    = 2'd2,
        LOAD_NONE = 2'd3
    } load_t;

    typedef struct packed {
        logic [TC_WID_W-1:0] wid;
        logic [TC_RD_W-1:0]  rd;
        logic                wb_reg;
        logic                last;
        logic [TC_ROW_W-1:0] data;
    } res_entry_t;

    // A tile destination is {tile_reg, tile_buf}; only the populated slots are legal.
    function automatic logic tile_idx_ok(input logic [TC_RD_W-1:0] rd);
        return 32'(rd) < 32'(TC_NUM_TILE_REGS * TC_NUM_TILE_BUFS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tensor_result_fifo.sv
// ============================================================================
//  Module      : tensor_result_fifo
//  Description : Synchronous FIFO of result rows with full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tensor_result_fifo
    import tensor_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  res_entry_t push_entry,
    input  logic       pop,
    output res_entry_t pop_entry,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    res_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra bit so full and empty differ only in the MSB.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign pop_entry = mem_q[rd_ptr_q[PTR_W-2:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-2:0]] <= push_entry;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tensor_result_commit.sv
// ============================================================================
//  Module      : tensor_result_commit
//  Description : Buffers tensor result rows and routes them to register commit
//                or tile-buffer write, with per-warp busy and done tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tensor_result_commit
    import tensor_pkg::*;
#(
    parameter  int NUM_THREADS   = TC_NUM_THREADS,
    parameter  int XLEN          = TC_XLEN,
    parameter  int NUM_WARPS     = TC_NUM_WARPS,
    parameter  int NUM_REGS      = TC_NUM_REGS,
    parameter  int NUM_TILE_BUFS = TC_NUM_TILE_BUFS,
    parameter  int FIFO_DEPTH    = 4,
    localparam int WID_W         = $clog2(NUM_WARPS),
    localparam int RD_W          = $clog2(NUM_REGS),
    localparam int ROW_W         = NUM_THREADS * XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [WID_W-1:0]     res_wid,
    input  logic [RD_W-1:0]      res_rd,
    input  logic                 res_wb_reg,
    input  logic                 res_last,
    input  logic [ROW_W-1:0]     res_data,
    output logic                 cmt_valid,
    input  logic                 cmt_ready,
    output logic [WID_W-1:0]     cmt_wid,
    output logic [RD_W-1:0]      cmt_rd,
    output logic [ROW_W-1:0]     cmt_data,
    output logic                 cmt_eop,
    output logic                 tb_wr_en,
    output logic [RD_W-1:0]      tb_wr_idx,
    output logic [ROW_W-1:0]     tb_wr_data,
    output logic                 done_valid,
    output logic [WID_W-1:0]     done_wid,
    output logic [NUM_WARPS-1:0] busy
);

    localparam int CNT_W      = $clog2(FIFO_DEPTH + 2);
    localparam int TILE_SLOTS = TC_NUM_TILE_REGS * NUM_TILE_BUFS;

    res_entry_t in_entry;
    res_entry_t head_entry;
    res_entry_t stg_q, stg_d;
    logic       stg_valid_q, stg_valid_d;
    logic       ready_en_q, ready_en_d;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       retire;

    always_comb begin
        in_entry        = '0;
        in_entry.wid    = res_wid;
        in_entry.rd     = res_rd;
        in_entry.wb_reg = res_wb_reg;
        in_entry.last   = res_last;
        in_entry.data   = res_data;
    end

    // ready_en keeps res_ready low through reset and for the first cycle after.
    assign res_ready = ready_en_q && !fifo_full;
    assign push      = res_valid && res_ready;
    assign retire    = stg_valid_q && (!stg_q.wb_reg || cmt_ready);
    assign pop       = !fifo_empty && (!stg_valid_q || retire);

    tensor_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (in_entry),
        .pop        (pop),
        .pop_entry  (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        ready_en_d  = 1'b1;
        stg_valid_d = stg_valid_q;
        stg_d       = stg_q;
        if (retire) begin
            stg_valid_d = 1'b0;
        end
        if (pop) begin
            stg_valid_d = 1'b1;
            stg_d       = head_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            stg_valid_q <= 1'b0;
            stg_q       <= '0;
        end else begin
            ready_en_q  <= ready_en_d;
            stg_valid_q <= stg_valid_d;
            stg_q       <= stg_d;
        end
    end

    assign cmt_valid  = stg_valid_q && stg_q.wb_reg;
    assign cmt_wid    = stg_q.wid;
    assign cmt_rd     = stg_q.rd;
    assign cmt_data   = stg_q.data;
    assign cmt_eop    = stg_q.last;
    assign tb_wr_en   = stg_valid_q && !stg_q.wb_reg;
    assign tb_wr_idx  = stg_q.rd;
    assign tb_wr_data = stg_q.data;

    // A retire in the reset cycle is discarded, so it must not signal completion.
    assign done_valid = rst_n && retire && stg_q.last;
    assign done_wid   = stg_q.wid;

    generate
        for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             inc;
            logic             dec;

            assign inc = push && (res_wid == WID_W'(w));
            assign dec = retire && (stg_q.wid == WID_W'(w));

            always_comb begin
                cnt_d = cnt_q;
                if (inc && !dec) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!inc && dec) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign busy[w] = (cnt_q != '0);
        end
    endgenerate

    a_tile_idx : assert property (@(posedge clk) disable iff (!rst_n)
        (res_valid && !res_wb_reg) |-> tile_idx_ok(res_rd))
        else $fatal(1, "tile destination %0d outside %0d slots", res_rd, TILE_SLOTS);

endmodule

`default_nettype wire

// File: tb/tb_tensor_result_commit.sv
// ============================================================================
//  Module      : tb_tensor_result_commit
//  Description : Directed bench for tensor_result_commit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tensor_result_commit;

    localparam int NT    = 32;
    localparam int XL    = 32;
    localparam int NW    = 8;
    localparam int WID_W = 3;
    localparam int RD_W  = 5;
    localparam int ROW_W = NT * XL;

    logic              clk;
    logic              rst_n;
    logic              res_valid;
    logic              res_ready;
    logic [WID_W-1:0]  res_wid;
    logic [RD_W-1:0]   res_rd;
    logic              res_wb_reg;
    logic              res_last;
    logic [ROW_W-1:0]  res_data;
    logic              cmt_valid;
    logic              cmt_ready;
    logic [WID_W-1:0]  cmt_wid;
    logic [RD_W-1:0]   cmt_rd;
    logic [ROW_W-1:0]  cmt_data;
    logic              cmt_eop;
    logic              tb_wr_en;
    logic [RD_W-1:0]   tb_wr_idx;
    logic [ROW_W-1:0]  tb_wr_data;
    logic              done_valid;
    logic [WID_W-1:0]  done_wid;
    logic [NW-1:0]     busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [ROW_W-1:0] exp_data;
    int               done_cnt;

    tensor_result_commit #(
        .NUM_THREADS   (NT),
        .XLEN          (XL),
        .NUM_WARPS     (NW),
        .NUM_REGS      (32),
        .NUM_TILE_BUFS (4),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_wid    (res_wid),
        .res_rd     (res_rd),
        .res_wb_reg (res_wb_reg),
        .res_last   (res_last),
        .res_data   (res_data),
        .cmt_valid  (cmt_valid),
        .cmt_ready  (cmt_ready),
        .cmt_wid    (cmt_wid),
        .cmt_rd     (cmt_rd),
        .cmt_data   (cmt_data),
        .cmt_eop    (cmt_eop),
        .tb_wr_en   (tb_wr_en),
        .tb_wr_idx  (tb_wr_idx),
        .tb_wr_data (tb_wr_data),
        .done_valid (done_valid),
        .done_wid   (done_wid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] mkdata(input int seed);
        logic [ROW_W-1:0] d;
        for (int i = 0; i < NT; i++) begin
            d[i*XL +: XL] = XL'(seed * 256 + i);
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int wid, input int rd, input logic wb, input logic last, input int seed);
        res_valid  = 1'b1;
        res_wid    = WID_W'(wid);
        res_rd     = RD_W'(rd);
        res_wb_reg = wb;
        res_last   = last;
        res_data   = mkdata(seed);
    endtask

    initial begin
        rst_n      = 1'b0;
        res_valid  = 1'b0;
        res_wid    = '0;
        res_rd     = '0;
        res_wb_reg = 1'b1;
        res_last   = 1'b0;
        res_data   = '0;
        cmt_ready  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", 64'(res_ready), 64'd0);
        check("rst_cmt_valid", 64'(cmt_valid), 64'd0);
        check("rst_tb_wr_en", 64'(tb_wr_en), 64'd0);
        check("rst_done", 64'(done_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        #1;
        check("ready_lag", 64'(res_ready), 64'd0);
        tick();
        check("ready_after_rst", 64'(res_ready), 64'd1);

        // Single register row, two-cycle latency, done on handshake
        cmt_ready = 1'b1;
        set_row(3, 5, 1'b1, 1'b1, 0);
        tick();
        res_valid = 1'b0;
        check("t1_valid_c1", 64'(cmt_valid), 64'd0);
        check("t1_busy_c1", 64'(busy), 64'h08);
        tick();
        exp_data = mkdata(0);
        check("t1_valid_c2", 64'(cmt_valid), 64'd1);
        check("t1_rd", 64'(cmt_rd), 64'd5);
        check("t1_wid", 64'(cmt_wid), 64'd3);
        check("t1_eop", 64'(cmt_eop), 64'd1);
        check("t1_data_lo", cmt_data[63:0], exp_data[63:0]);
        check("t1_data_full", 64'(cmt_data == exp_data), 64'd1);
        check("t1_done", 64'(done_valid), 64'd1);
        check("t1_done_wid", 64'(done_wid), 64'd3);
        tick();
        check("t1_valid_after", 64'(cmt_valid), 64'd0);
        check("t1_done_after", 64'(done_valid), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);

        // Two tile rows back to back
        set_row(1, 6, 1'b0, 1'b0, 1);
        tick();
        set_row(1, 6, 1'b0, 1'b1, 2);
        tick();
        res_valid  = 1'b0;
        res_wb_reg = 1'b1;
        check("t2_wr0", 64'(tb_wr_en), 64'd1);
        check("t2_idx0", 64'(tb_wr_idx), 64'd6);
        check("t2_cmt0", 64'(cmt_valid), 64'd0);
        check("t2_done0", 64'(done_valid), 64'd0);
        check("t2_busy0", 64'(busy), 64'h02);
        tick();
        exp_data = mkdata(2);
        check("t2_wr1", 64'(tb_wr_en), 64'd1);
        check("t2_idx1", 64'(tb_wr_idx), 64'd6);
        check("t2_data1", tb_wr_data[63:0], exp_data[63:0]);
        check("t2_done1", 64'(done_valid), 64'd1);
        check("t2_done_wid", 64'(done_wid), 64'd1);
        tick();
        check("t2_wr_end", 64'(tb_wr_en), 64'd0);
        check("t2_done_end", 64'(done_valid), 64'd0);
        check("t2_busy_end", 64'(busy), 64'd0);

        // Backpressure: five rows fill FIFO plus stage
        cmt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_row(4, 10 + k, 1'b1, 1'b0, 16 + k);
            check($sformatf("t3_ready_%0d", k), 64'(res_ready), 64'd1);
            tick();
        end
        check("t3_full_ready", 64'(res_ready), 64'd0);
        check("t3_hold_valid", 64'(cmt_valid), 64'd1);
        check("t3_hold_rd", 64'(cmt_rd), 64'd10);
        set_row(4, 15, 1'b1, 1'b1, 21);
        tick();
        exp_data = mkdata(16);
        check("t3_still_full", 64'(res_ready), 64'd0);
        check("t3_stable_rd", 64'(cmt_rd), 64'd10);
        check("t3_stable_data", cmt_data[63:0], exp_data[63:0]);
        check("t3_busy", 64'(busy), 64'h10);

        // Full with push attempt and pop in the same cycle
        cmt_ready = 1'b1;
        tick();
        check("t3_pop_ready", 64'(res_ready), 64'd1);
        check("t3_pop_rd", 64'(cmt_rd), 64'd11);
        check("t3_pop_done", 64'(done_valid), 64'd0);
        tick();
        res_valid = 1'b0;
        check("t3_rd12", 64'(cmt_rd), 64'd12);
        for (int k = 3; k <= 5; k++) begin
            tick();
            check($sformatf("t3_valid_%0d", k), 64'(cmt_valid), 64'd1);
            check($sformatf("t3_rd_%0d", k), 64'(cmt_rd), 64'(10 + k));
            check($sformatf("t3_done_%0d", k), 64'(done_valid), 64'(k == 5));
        end
        check("t3_done_wid", 64'(done_wid), 64'd4);
        tick();
        check("t3_drained", 64'(cmt_valid), 64'd0);
        check("t3_busy_end", 64'(busy), 64'd0);

        // Interleaved warps 0 and 2; row n pushed at tick n+1, staged after tick n+2
        done_cnt = 0;
        for (int j = 1; j <= 10; j++) begin
            if (j <= 8) begin
                set_row(((j - 1) % 2 == 1) ? 2 : 0, j - 1, 1'b1, (j - 1) >= 6, 32 + j);
            end else begin
                res_valid = 1'b0;
            end
            tick();
            if (j >= 2) begin
                automatic int  n  = j - 2;
                automatic logic b0 = 1'b0;
                automatic logic b2 = 1'b0;
                for (int m = n; m <= ((j - 1 > 7) ? 7 : j - 1); m++) begin
                    if (m % 2 == 0) b0 = 1'b1;
                    else            b2 = 1'b1;
                end
                if (n <= 7) begin
                    check($sformatf("t4_valid_%0d", n), 64'(cmt_valid), 64'd1);
                    check($sformatf("t4_rd_%0d", n), 64'(cmt_rd), 64'(n));
                    check($sformatf("t4_wid_%0d", n), 64'(cmt_wid), (n % 2 == 1) ? 64'd2 : 64'd0);
                    check($sformatf("t4_done_%0d", n), 64'(done_valid), 64'(n >= 6));
                end
                check($sformatf("t4_busy0_%0d", j), 64'(busy[0]), 64'(b0));
                check($sformatf("t4_busy2_%0d", j), 64'(busy[2]), 64'(b2));
            end
            if (done_valid) done_cnt++;
        end
        check("t4_done_count", 64'(done_cnt), 64'd2);

        // Reset with three rows queued and one in the stage
        cmt_ready = 1'b0;
        set_row(5, 1, 1'b1, 1'b1, 40);
        tick();
        for (int k = 2; k <= 4; k++) begin
            set_row(5, k, 1'b1, 1'b0, 40 + k);
            tick();
        end
        res_valid = 1'b0;
        check("t5_pre_valid", 64'(cmt_valid), 64'd1);
        check("t5_pre_rd", 64'(cmt_rd), 64'd1);
        check("t5_pre_busy", 64'(busy), 64'h20);
        rst_n     = 1'b0;
        cmt_ready = 1'b1;
        #1;
        check("t5_no_done_in_rst", 64'(done_valid), 64'd0);
        tick();
        check("t5_ready", 64'(res_ready), 64'd0);
        check("t5_cmt_valid", 64'(cmt_valid), 64'd0);
        check("t5_cmt_wid", 64'(cmt_wid), 64'd0);
        check("t5_cmt_rd", 64'(cmt_rd), 64'd0);
        check("t5_cmt_data", 64'(cmt_data == '0), 64'd1);
        check("t5_tb_wr_en", 64'(tb_wr_en), 64'd0);
        check("t5_done", 64'(done_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();
        check("t5_ready_back", 64'(res_ready), 64'd1);
        tick();
        check("t5_empty", 64'(cmt_valid), 64'd0);
        check("t5_empty_done", 64'(done_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
